uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
- Shares the peripheral UART transmitter between two byte producers: req0 (CPU store path) and req1 (hardware source, e.g. RX echo or debug trace).
- Round-robin arbiter feeds a small FIFO. A sequencing FSM drains the FIFO into the UART: one tx_enable pulse per byte, waits for the frame to finish, then enforces an inter-frame gap.
- Sits between the bus-side peripheral register logic and the uart instance. It is the single owner of uart tx_data/tx_enable.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- GAP_CYCLES, 16, idle clk cycles between the end of one frame and the next launch; 0 means no gap.
- TIMEOUT_CYCLES, 1024, maximum cycles to wait for the UART to go busy after launch. Used only with the optional feature.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-low reset.
- req0_valid  in  1  requester 0 has a byte.
- req0_data  in  8  requester 0 byte.
- req0_ready  out  1  requester 0 byte accepted this cycle.
- req1_valid  in  1  requester 1 has a byte.
- req1_data  in  8  requester 1 byte.
- req1_ready  out  1  requester 1 byte accepted this cycle.
- uart_tx_data  out  8  byte presented to the uart; held stable from launch until the frame is done.
- uart_tx_enable  out  1  one-cycle launch pulse to the uart.
- uart_tx_status  in  1  uart transmitter idle (1) / busy (0); asynchronous to clk.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- busy  out  1  FSM not in IDLE, or FIFO not empty.

Behaviour:
- Reset (clk edge with reset=0):
  - FIFO empty; fifo_level=0; state=IDLE.
  - uart_tx_data=8'h00; uart_tx_enable=0; busy=0.
  - RR pointer favours req0; synchronizer flops preset to 1 (idle).
  - Reset mid-frame abandons the byte and flushes the FIFO. The uart finishes its own frame.
- Synchronizer: uart_tx_status passes through two flops to give st_s. The FSM uses only st_s.
- Arbitration:
  - When the FIFO is not full, at most one ready is asserted per cycle. Readys are combinational from valid, the registered count and the RR pointer.
  - Both valid: grant the requester not granted last; the pointer updates only on a grant.
  - Only one valid: grant it.
  - Full is judged on the registered count before the same-cycle pop, so there is no bypass. At full, both readys are 0 even if a pop occurs.
- FIFO:
  - Write on ready&&valid; pop on the IDLE->LAUNCH transition.
  - Pointers wrap modulo DEPTH.
  - fifo_level is +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- FSM:
  - IDLE: if FIFO not empty and st_s=1, load uart_tx_data from the FIFO head, pop, go to LAUNCH.
  - LAUNCH: uart_tx_enable=1 for exactly this cycle; go to WAIT_START.
  - WAIT_START: on st_s=0, go to WAIT_DONE.
  - WAIT_DONE: on st_s=1, go to GAP and load gap counter = GAP_CYCLES-1. If GAP_CYCLES=0, go straight to IDLE.
  - GAP: count down; at 0, go to IDLE.
- Latency: a byte accepted into an empty FIFO while idle gives uart_tx_enable high in the 2nd cycle after the accept cycle.
- Ordering: bytes leave in acceptance order. There is no per-requester reordering.

Optional Feature:
- Macro: UART_TX_SCHED_TIMEOUT_EN.
- Enabled:
  - Adds output err_timeout (1 bit, reset 0, sticky until reset).
  - A counter runs in WAIT_START. If st_s has not gone to 0 within TIMEOUT_CYCLES cycles, set err_timeout and go to IDLE; the byte is dropped.
- Disabled: no port and no counter; WAIT_START waits indefinitely.

Test Plan:
- Single byte: req0 sends 8'hA5 with st_s idle -> one uart_tx_enable pulse 2 cycles after accept, uart_tx_data=8'hA5; the bench model drops status for 100 cycles -> busy falls GAP_CYCLES+1 cycles after st_s returns to 1.
- Contention: req0 and req1 both valid continuously with bytes 0x10.. and 0x80.. -> grants alternate req0, req1, req0…; UART output order 0x10, 0x80, 0x11, 0x81.
- Full: status held busy, 10 pushes with DEPTH=8 -> exactly 8 accepted (9 if the first byte is popped first); readys then 0, fifo_level=8; release status -> all bytes drain in order.
- Simultaneous push/pop at full: pop in the same cycle as a valid request -> no accept that cycle, accept the next cycle, fifo_level 8→7→8.
- Reset mid-frame: reset=0 for one clk in WAIT_DONE with 3 bytes queued -> next cycle fifo_level=0, state IDLE, uart_tx_enable=0, uart_tx_data=0; no further pulses.
- With UART_TX_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16: status stuck at 1 after launch -> err_timeout=1 after 16 cycles in WAIT_START, FSM returns to IDLE and launches the next queued byte.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin two-producer byte scheduler feeding a single UART transmitter.
// Define UART_TX_SCHED_TIMEOUT_EN to add the launch-timeout watchdog (err_timeout).
module uart_tx_scheduler #(
  parameter int DEPTH          = 8,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0_valid,
  input  logic [7:0]             req0_data,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [7:0]             req1_data,
  output logic                   req1_ready,
  output logic [7:0]             uart_tx_data,
  output logic                   uart_tx_enable,
  input  logic                   uart_tx_status,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   busy
`ifdef UART_TX_SCHED_TIMEOUT_EN
  ,
  output logic                   err_timeout
`endif
);

  localparam int AW   = $clog2(DEPTH);
  localparam int MAXG = (GAP_CYCLES > TIMEOUT_CYCLES)
                      ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int MAXC = (MAXG > 1) ? MAXG : 1;
  // One down-counter serves both the gap and the launch watchdog.
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_START,
    WAIT_DONE,
    GAP
  } state_t;

  state_t         state, state_d;
  logic [CW-1:0]  cnt, cnt_d;
  logic [7:0]     data_d;
  logic           st_q, st_s;
  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic           prio;
  logic           full, push, pop;
  logic           gnt0, gnt1;
  logic [7:0]     wdata;
`ifdef UART_TX_SCHED_TIMEOUT_EN
  logic           err_d;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q <= 1'b1;
      st_s <= 1'b1;
    end else begin
      st_q <= uart_tx_status;
      st_s <= st_q;
    end
  end

  // Full uses the registered count, so a same-cycle pop never frees a slot.
  assign full  = (count == (AW+1)'(DEPTH));
  assign gnt0  = !full && req0_valid && (!req1_valid || !prio);
  assign gnt1  = !full && req1_valid && (!req0_valid || prio);
  assign push  = gnt0 || gnt1;
  assign wdata = gnt1 ? req1_data : req0_data;

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign fifo_level = count;
  assign busy       = (state != IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      prio   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (gnt0)      prio <= 1'b1;
      else if (gnt1) prio <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      uart_tx_data <= 8'h00;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      err_timeout  <= 1'b0;
`endif
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      uart_tx_data <= data_d;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      err_timeout  <= err_d;
`endif
    end
  end

  always_comb begin
    state_d        = state;
    cnt_d          = cnt;
    data_d         = uart_tx_data;
    pop            = 1'b0;
    uart_tx_enable = 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    err_d          = err_timeout;
`endif
    unique case (state)
      IDLE: begin
        if ((count != '0) && st_s) begin
          data_d  = mem[rd_ptr];
          pop     = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        uart_tx_enable = 1'b1;
        state_d        = WAIT_START;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        cnt_d          = CW'(TIMEOUT_CYCLES - 1);
`endif
      end
      WAIT_START: begin
        if (!st_s) begin
          state_d = WAIT_DONE;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        end else if (cnt == '0) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt - CW'(1);
`endif
        end
      end
      WAIT_DONE: begin
        if (st_s) begin
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            cnt_d   = CW'(GAP_CYCLES - 1);
          end
        end
      end
      GAP: begin
        if (cnt == '0) state_d = IDLE;
        else           cnt_d   = cnt - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: latency, RR, full, reset flush.
// Build with UART_TX_SCHED_TIMEOUT_EN to also exercise the watchdog.
module tb_uart_tx_scheduler;

  localparam int DEPTH = 8;
  localparam int GAP   = 16;
  localparam int TMO   = 16;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   req0_valid = 1'b0;
  logic [7:0]             req0_data = 8'h00;
  logic                   req0_ready;
  logic                   req1_valid = 1'b0;
  logic [7:0]             req1_data = 8'h00;
  logic                   req1_ready;
  logic [7:0]             uart_tx_data;
  logic                   uart_tx_enable;
  logic                   uart_tx_status;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                   busy;
`ifdef UART_TX_SCHED_TIMEOUT_EN
  logic                   err_timeout;
`endif

  logic       man = 1'b1;
  logic       man_st = 1'b1;
  logic       hold = 1'b0;
  logic       st_drv = 1'b1;
  logic [7:0] got [$];
  logic [7:0] exp2 [4] = '{8'h10, 8'h80, 8'h11, 8'h81};
  int         n_cmp = 0;
  int         n_bad = 0;

  assign uart_tx_status = man ? man_st : (st_drv & ~hold);

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .DEPTH(DEPTH),
    .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req0_valid(req0_valid),
    .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_data(req1_data),
    .req1_ready(req1_ready),
    .uart_tx_data(uart_tx_data),
    .uart_tx_enable(uart_tx_enable),
    .uart_tx_status(uart_tx_status),
    .fifo_level(fifo_level),
    .busy(busy)
`ifdef UART_TX_SCHED_TIMEOUT_EN
    ,
    .err_timeout(err_timeout)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Simple UART: goes busy the cycle after a launch, stays busy 3 cycles.
  initial forever begin
    @(negedge clk);
    if (!man && uart_tx_enable) begin
      got.push_back(uart_tx_data);
      @(posedge clk);
      #1;
      st_drv = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      st_drv = 1'b1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc, a0, a1, pulses;

    reset = 1'b0;
    tick();
    tick();
    chk("rst_level", fifo_level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_en", uart_tx_enable, 0);
    chk("rst_data", uart_tx_data, 8'h00);
    reset = 1'b1;
    tick();

    // single byte latency and gap
    req0_valid = 1'b1;
    req0_data  = 8'hA5;
    #1;
    chk("t1_ready0", req0_ready, 1);
    chk("t1_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    chk("t1_level1", fifo_level, 1);
    chk("t1_en_early", uart_tx_enable, 0);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_en", uart_tx_enable, 1);
    chk("t1_data", uart_tx_data, 8'hA5);
    chk("t1_level0", fifo_level, 0);
    tick();
    man_st = 1'b0;
    chk("t1_en_once", uart_tx_enable, 0);
    repeat (100) tick();
    chk("t1_hold_data", uart_tx_data, 8'hA5);
    man_st = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < 100);
    chk("t1_gap_cycles", n, 19);

    // contention
    reset = 1'b0;
    tick();
    reset = 1'b1;
    man = 1'b0;
    got.delete();
    a0 = 0;
    a1 = 0;
    for (int k = 0; k < 4; k++) begin
      req0_valid = 1'b1;
      req0_data  = 8'(8'h10 + a0);
      req1_valid = 1'b1;
      req1_data  = 8'(8'h80 + a1);
      #1;
      chk($sformatf("t2_gnt0_%0d", k), req0_ready, (k % 2 == 0));
      chk($sformatf("t2_gnt1_%0d", k), req1_ready, (k % 2 == 1));
      if (req0_ready) a0++;
      else if (req1_ready) a1++;
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n = 0;
    while ((got.size() < 4 || busy) && n < 1000) begin
      tick();
      n++;
    end
    chk("t2_drain_done", (n < 1000), 1);
    chk("t2_count", got.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t2_order_%0d", i), got[i], exp2[i]);

    // fill to full with the UART held busy
    hold = 1'b1;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (3) tick();
    got.delete();
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      req0_valid = 1'b1;
      req0_data  = 8'(8'h20 + i);
      #1;
      if (req0_ready) acc++;
      tick();
    end
    chk("t3_accepted", acc, 8);
    chk("t3_level", fifo_level, 8);
    req1_valid = 1'b1;
    req1_data  = 8'h40;
    #1;
    chk("t3_ready0_full", req0_ready, 0);
    chk("t3_ready1_full", req1_ready, 0);
    req0_valid = 1'b0;
    #1;
    chk("t3_ready1_only", req1_ready, 0);

    // pop and push contend at full
    hold = 1'b0;
    tick();
    tick();
    chk("t4_pop_level", fifo_level, 8);
    chk("t4_pop_ready", req1_ready, 0);
    tick();
    chk("t4_after_level", fifo_level, 7);
    chk("t4_after_ready", req1_ready, 1);
    chk("t4_after_en", uart_tx_enable, 1);
    tick();
    chk("t4_refill_level", fifo_level, 8);
    chk("t4_refill_ready", req1_ready, 0);
    req1_valid = 1'b0;
    n = 0;
    while ((got.size() < 9 || busy) && n < 3000) begin
      tick();
      n++;
    end
    chk("t4_drain_done", (n < 3000), 1);
    chk("t4_count", got.size(), 9);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t4_order_%0d", i), got[i], 8'(8'h20 + i));
    chk("t4_order_8", got[8], 8'h40);

    // reset mid-frame
    man = 1'b1;
    man_st = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'b1;
      req0_data  = 8'(8'h50 + i);
      #1;
      chk($sformatf("t5_acc_%0d", i), req0_ready, 1);
      tick();
    end
    req0_valid = 1'b0;
    man_st = 1'b0;
    repeat (6) tick();
    chk("t5_pre_level", fifo_level, 3);
    chk("t5_pre_busy", busy, 1);
    reset = 1'b0;
    tick();
    chk("t5_level", fifo_level, 0);
    chk("t5_busy", busy, 0);
    chk("t5_en", uart_tx_enable, 0);
    chk("t5_data", uart_tx_data, 8'h00);
    reset = 1'b1;
    man_st = 1'b1;
    pulses = 0;
    repeat (40) begin
      tick();
      if (uart_tx_enable) pulses++;
    end
    chk("t5_no_pulses", pulses, 0);

`ifdef UART_TX_SCHED_TIMEOUT_EN
    // UART never goes busy
    chk("t6_err_init", err_timeout, 0);
    for (int i = 0; i < 2; i++) begin
      req0_valid = 1'b1;
      req0_data  = 8'(8'h61 + i);
      tick();
    end
    req0_valid = 1'b0;
    n = 0;
    while (!uart_tx_enable && n < 10) begin
      tick();
      n++;
    end
    chk("t6_first_data", uart_tx_data, 8'h61);
    n = 0;
    while (!err_timeout && n < 100) begin
      tick();
      n++;
    end
    chk("t6_tmo_cycles", n, 17);
    n = 0;
    while (!uart_tx_enable && n < 10) begin
      tick();
      n++;
    end
    chk("t6_relaunch", uart_tx_enable, 1);
    chk("t6_second_data", uart_tx_data, 8'h62);
    chk("t6_err_sticky", err_timeout, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
